// File: rtl/i2c_codec_target.sv
// I2C target that receives 24-bit codec register writes (address, {reg,d8}, d[7:0]) and
// ACKs them. It oversamples SCL/SDA on clk and emits one strobe per completed write.
module i2c_codec_target #(
  parameter logic [6:0]  ADDRESS     = 7'h1a,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAckA, StByteHi, StAckH, StByteLo, StAckL, StIgnore
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [7:0]  shift_in;
  logic [7:0]  hi_q, hi_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        wr_valid_q, wr_valid_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic [8:0]  wr_data_q, wr_data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  // SCL must be stable high across the SDA edge; a coincident SCL edge wins.
  assign start_det = scl_s & scl_prev_q & ~sda_s & sda_prev_q;
  assign stop_det  = scl_s & scl_prev_q & sda_s & ~sda_prev_q;
  assign shift_in  = {shift_q, sda_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      hi_q       <= '0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      hi_q       <= hi_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    hi_d       = hi_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (stop_det) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = StAddr;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StIgnore: ;
        StAddr, StByteHi, StByteLo: begin
          if (scl_rise) begin
            shift_d = shift_in[6:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (state_q == StAddr) begin
                state_d = (shift_in == {ADDRESS, 1'b0}) ? StAckA : StIgnore;
              end else if (state_q == StByteHi) begin
                hi_d    = shift_in;
                state_d = StAckH;
              end else begin
                wr_valid_d = 1'b1;
                wr_addr_d  = hi_q[7:1];
                wr_data_d  = {hi_q[0], shift_in};
                state_d    = StAckL;
              end
            end
          end
        end
        StAckA, StAckH, StAckL: begin
          // First SCL fall pulls SDA low for the ACK bit, the next one releases it.
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
              if (state_q == StAckA) busy_d = 1'b1;
            end else begin
              oe_d = 1'b0;
              unique case (state_q)
                StAckA:  state_d = StByteHi;
                StAckH:  state_d = StByteLo;
                default: state_d = StIgnore;
              endcase
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign sda = oe_q ? 1'b0 : 1'bz;

  always_comb begin
    wr_valid = wr_valid_q;
    wr_addr  = wr_addr_q;
    wr_data  = wr_data_q;
    busy     = busy_q;
  end

endmodule

// File: tb/tb_i2c_codec_target.sv
// Bench for i2c_codec_target: a bit-banged I2C master drives directed and random frames and
// compares ACKs, busy and the write strobe against a frame-level model.
module tb_i2c_codec_target;

  localparam logic [6:0] ADDR = 7'h1a;
  localparam logic [7:0] WADDR = {ADDR, 1'b0};

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       drv = 1'b0;
  wire        sda;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int wv_count = 0;
  logic [6:0] cap_addr = '0;
  logic [8:0] cap_data = '0;

  int         m_writes = 0;
  logic [6:0] m_addr = '0;
  logic [8:0] m_data = '0;
  logic       m_busy = 1'b0;

  pullup (sda);
  assign sda = drv ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_codec_target #(.ADDRESS(ADDR), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      wv_count++;
      cap_addr = wr_addr;
      cap_data = wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic start_cond();
    if (scl == 1'b0) begin
      wait_q(); drv = 1'b0;
      wait_q(); scl = 1'b1;
    end
    wait_q(); drv = 1'b1;
    wait_q(); scl = 1'b0;
  endtask

  task automatic stop_cond();
    wait_q(); drv = 1'b1;
    wait_q(); scl = 1'b1;
    wait_q(); drv = 1'b0;
    wait_q();
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      wait_q(); drv = ~b[i];
      wait_q(); scl = 1'b1;
      wait_q(); wait_q(); scl = 1'b0;
    end
  endtask

  task automatic ack_bit(output logic a);
    wait_q(); drv = 1'b0;
    wait_q(); scl = 1'b1;
    wait_q(); a = (sda === 1'b0);
    wait_q(); scl = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " writes"}, wv_count, m_writes);
    check({tag, " wr_addr"}, wr_addr, m_addr);
    check({tag, " wr_data"}, wr_data, m_data);
    if (m_writes > 0) begin
      check({tag, " strobe addr"}, cap_addr, m_addr);
      check({tag, " strobe data"}, cap_data, m_data);
    end
  endtask

  task automatic do_stop(input string tag);
    stop_cond();
    m_busy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check({tag, " busy after stop"}, busy, 1'b0);
  endtask

  // Model: only a write to ADDR is ACKed, for the address and two data bytes; any further
  // byte is NACKed. A write lands once the third byte has been shifted in.
  task automatic send_frame(input bq_t bytes, input logic stop, input string tag);
    logic a;
    logic addr_ok;
    start_cond();
    addr_ok = (bytes[0] == WADDR);
    for (int i = 0; i < bytes.size(); i++) begin
      send_bits(bytes[i]);
      ack_bit(a);
      check($sformatf("%s ack%0d", tag, i), a, addr_ok && (i < 3));
      if (i == 0 && addr_ok) m_busy = 1'b1;
      check($sformatf("%s busy%0d", tag, i), busy, m_busy);
    end
    if (addr_ok && bytes.size() >= 3) begin
      m_writes++;
      m_addr = bytes[1][7:1];
      m_data = {bytes[1][0], bytes[2]};
    end
    if (stop) do_stop(tag);
    check_outputs(tag);
  endtask

  initial begin
    bq_t q;
    logic [7:0] b0;
    int kind;
    logic stop;

    repeat (3) @(posedge clk);
    #1;
    check("reset wr_valid", wr_valid, 1'b0);
    check("reset wr_addr", wr_addr, 7'd0);
    check("reset wr_data", wr_data, 9'd0);
    check("reset busy", busy, 1'b0);
    check("reset sda", sda, 1'b1);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    q = {8'h34, 8'h1E, 8'h00};            send_frame(q, 1'b1, "t1");
    q = {8'h34, 8'h0C, 8'h0E};            send_frame(q, 1'b1, "t2a");
    q = {8'h34, 8'h09, 8'h9F};            send_frame(q, 1'b1, "t2b");
    q = {8'h50, 8'h11};                   send_frame(q, 1'b1, "t3 wrong addr");
    q = {8'h35, 8'h11};                   send_frame(q, 1'b1, "t3 read");
    q = {8'h34, 8'h1E};                   send_frame(q, 1'b0, "t4 partial");
    q = {8'h34, 8'h0A, 8'h3C};            send_frame(q, 1'b1, "t4 rstart");
    q = {8'h34, 8'h08, 8'h12, 8'h55};     send_frame(q, 1'b1, "t5 extra");

    // Reset asserted while the target holds the ACK after the high data byte.
    start_cond();
    send_bits(8'h34);
    ack_bit(b0[0]);
    check("t6 addr ack", b0[0], 1'b1);
    send_bits(8'h2B);
    wait_q(); drv = 1'b0;
    wait_q();
    check("t6 ack drive", sda, 1'b0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("t6 sda released", sda, 1'b1);
    check("t6 busy", busy, 1'b0);
    check("t6 wr_addr", wr_addr, 7'd0);
    check("t6 wr_data", wr_data, 9'd0);
    m_busy = 1'b0;
    m_addr = '0;
    m_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    do_stop("t6");
    q = {8'h34, 8'h2B, 8'hC4};            send_frame(q, 1'b1, "t6 after");

    for (int n = 0; n < 16; n++) begin
      kind = $urandom_range(0, 3);
      b0 = WADDR;
      if (kind == 1) begin
        b0 = 8'($urandom);
        if (b0 == WADDR) b0 = 8'h35;
      end
      q = {b0};
      for (int k = 0; k < ((kind == 0) ? 2 : (kind == 1) ? $urandom_range(0, 2) :
                           (kind == 2) ? 1 : 3); k++) begin
        q.push_back(8'($urandom));
      end
      stop = ($urandom_range(0, 3) != 0);
      send_frame(q, stop, $sformatf("rnd%0d", n));
    end
    do_stop("final");
    check("final writes", wv_count, m_writes);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
